// File: rtl/cmos_dvp_pattern_gen.sv
// Synthetic DVP camera source: produces gray test frames with OmniVision-style
// vsync/href timing so the capture path can run without a physical sensor.
module cmos_dvp_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned V_BACK   = 16,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned VS_SYNC  = 4
) (
    input  logic       cmos_pclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       cmos_vsync,
    output logic       cmos_href,
    output logic [7:0] cmos_data,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_BACK + V_ACTIVE + V_FRONT + VS_SYNC;

    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_END    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_FIRST  = 12'(V_BACK);
    localparam logic [11:0] V_ACT_LAST   = 12'(V_BACK + V_ACTIVE - 1);
    // First line of the vsync-low gap.
    localparam logic [11:0] V_SYNC_START = 12'(V_BACK + V_ACTIVE + V_FRONT);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [1:0]  pat_q, pat_d;

    logic        vsync_d, href_d, done_d;
    logic [7:0]  data_d, fcnt_d;
    logic        at_origin;
    logic [1:0]  pat_eff;
    logic [7:0]  x, y;
    logic [11:0] y_full;

    assign at_origin = (state_q == StRun) && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    // At the origin the pattern is being latched this cycle, so use it directly.
    assign pat_eff   = at_origin ? pattern_sel : pat_q;
    assign x         = h_cnt_q[7:0];
    assign y_full    = v_cnt_q - V_ACT_FIRST;
    assign y         = y_full[7:0];
    assign busy      = (state_q == StRun);

    // State register, raster counters and latched pattern.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            pat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pat_q   <= pat_d;
        end
    end

    // Next state: start on enable, free-run the raster, stop only at frame end.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        pat_d   = pat_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRun;
                    h_cnt_d = 12'd0;
                    v_cnt_d = 12'd0;
                end
            end
            StRun: begin
                if (at_origin) begin
                    pat_d = pattern_sel;
                end
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = 12'd0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = 12'd0;
                        if (!enable) begin
                            state_d = StIdle;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + 12'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the current counter position; registered below.
    always_comb begin
        vsync_d = 1'b0;
        href_d  = 1'b0;
        data_d  = 8'd0;
        done_d  = 1'b0;
        fcnt_d  = frame_cnt;
        if (state_q == StRun) begin
            vsync_d = (v_cnt_q < V_SYNC_START);
            href_d  = (v_cnt_q >= V_ACT_FIRST) && (v_cnt_q <= V_ACT_LAST) &&
                      (h_cnt_q < H_ACT_END);
            if (href_d) begin
                unique case (pat_eff)
                    2'd0: data_d = x;
                    2'd1: data_d = y;
                    2'd2: data_d = {8{x[3] ^ y[3]}};
                    2'd3: data_d = x + frame_cnt;
                    default: data_d = 8'd0;
                endcase
            end
            // Lands on the same edge where vsync drops.
            done_d = (h_cnt_q == 12'd0) && (v_cnt_q == V_SYNC_START);
            if (done_d) begin
                fcnt_d = frame_cnt + 8'd1;
            end
        end
    end

    // Registered DVP outputs and frame counter.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= 8'd0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            cmos_vsync <= vsync_d;
            cmos_href  <= href_d;
            cmos_data  <= data_d;
            frame_done <= done_d;
            frame_cnt  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_cmos_dvp_pattern_gen.sv
// Scoreboard bench for cmos_dvp_pattern_gen using a small raster.
// The reference model tracks a linear position within the frame and derives
// every output from that position with plain arithmetic.
module tb_cmos_dvp_pattern_gen;

    localparam int HA    = 8;
    localparam int HB    = 4;
    localparam int VB    = 1;
    localparam int VA    = 4;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int HT    = HA + HB;
    localparam int VT    = VB + VA + VF + VS;
    localparam int FRAME = HT * VT;
    localparam int SYNC  = VB + VA + VF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       cmos_vsync, cmos_href, frame_done, busy;
    logic [7:0] cmos_data, frame_cnt;

    cmos_dvp_pattern_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_BACK   (VB),
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .VS_SYNC  (VS)
    ) dut (
        .cmos_pclk   (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          started = 1'b0;
    logic [19:0] exp_q[$];

    // Reference model state.
    bit          m_run = 1'b0;
    int          m_p   = 0;
    logic [1:0]  m_pat = 2'd0;
    logic [7:0]  m_fc  = 8'd0;

    // {vsync, href, data} for linear frame position p.
    function automatic logic [9:0] pix(int p, logic [1:0] pat, logic [7:0] fc);
        int         h;
        int         v;
        logic       vs;
        logic       hr;
        logic [7:0] xx;
        logic [7:0] yy;
        logic [7:0] d;
        h  = p % HT;
        v  = p / HT;
        vs = (v < SYNC);
        hr = (v >= VB) && (v < VB + VA) && (h < HA);
        xx = 8'(h);
        yy = 8'(v - VB);
        d  = 8'd0;
        if (hr) begin
            case (pat)
                2'd0:    d = xx;
                2'd1:    d = yy;
                2'd2:    d = {8{xx[3] ^ yy[3]}};
                default: d = xx + fc;
            endcase
        end
        return {vs, hr, d};
    endfunction

    // One clock of stimulus; pushes what the DUT must show after the next edge.
    task automatic step(input bit en, input logic [1:0] ps);
        logic [9:0] o;
        bit         done;
        bit         nrun;
        logic [7:0] nfc;
        @(negedge clk);
        rst_n       = 1'b1;
        enable      = en;
        pattern_sel = ps;
        o    = 10'd0;
        done = 1'b0;
        if (m_run) begin
            o    = pix(m_p, (m_p == 0) ? ps : m_pat, m_fc);
            done = (m_p == SYNC * HT);
        end
        nrun = m_run ? ((m_p == FRAME - 1) ? en : 1'b1) : en;
        nfc  = done ? m_fc + 8'd1 : m_fc;
        exp_q.push_back({o, done, nfc, nrun});
        started = 1'b1;
        if (m_run) begin
            if (m_p == 0) m_pat = ps;
            m_p = (m_p == FRAME - 1) ? 0 : m_p + 1;
        end else begin
            m_p = 0;
        end
        m_run = nrun;
        m_fc  = nfc;
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy} !== 20'd0) begin
            n_fail++;
            $display("FAIL async_reset got vs=%b hr=%b d=%h fd=%b fc=%0d busy=%b want all 0",
                     cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy);
        end
        m_run = 1'b0;
        m_p   = 0;
        m_pat = 2'd0;
        m_fc  = 8'd0;
        exp_q.push_back(20'd0);
        started = 1'b1;
    endtask

    // Monitor: every output cycle is compared against the scoreboard head.
    initial begin
        logic [19:0] e;
        logic [19:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle t=%0t got vs=%b hr=%b d=%h fd=%b fc=%0d busy=%b want vs=%b hr=%b d=%h fd=%b fc=%0d busy=%b",
                             $time, a[19], a[18], a[17:10], a[9], a[8:1], a[0],
                             e[19], e[18], e[17:10], e[9], e[8:1], e[0]);
                end
            end else if (started) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow t=%0t got empty want entry", $time);
            end
        end
    end

    // Advance with enable held until the model reaches frame position target.
    task automatic run_to(input int target, input logic [1:0] ps);
        int guard;
        guard = 0;
        while (!(m_run && m_p == target) && guard < 4 * FRAME) begin
            step(1'b1, ps);
            guard++;
        end
        if (guard >= 4 * FRAME) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_to_timeout got pos=%0d want %0d", m_p, target);
        end
    endtask

    initial begin
        pulse_reset();
        pulse_reset();
        repeat (3) step(1'b0, 2'd0);

        // Pattern 0, two frames, then vertical ramp and moving ramp.
        repeat (2 * FRAME + 2) step(1'b1, 2'd0);
        run_to(0, 2'd1);
        repeat (FRAME) step(1'b1, 2'd1);
        repeat (3 * FRAME) step(1'b1, 2'd3);

        // Checker with pattern_sel churning mid-frame.
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 2'($urandom_range(0, 3)));

        // Stop requested mid active line; frame must finish, then stay idle.
        run_to(2 * HT + 3, 2'd2);
        repeat (2 * FRAME) step(1'b0, 2'd2);
        repeat (FRAME + 5) step(1'b1, 2'd0);

        // Stop cancelled before frame end.
        run_to(HT + 2, 2'd0);
        repeat (20) step(1'b0, 2'd0);
        repeat (FRAME) step(1'b1, 2'd0);

        // Reset in the middle of href, then a clean restart.
        run_to(3 * HT + 4, 2'd3);
        pulse_reset();
        repeat (2) step(1'b0, 2'd0);
        repeat (2 * FRAME + 3) step(1'b1, 2'd3);

        // Long randomized run; covers frame_cnt wrap.
        for (int i = 0; i < 262 * FRAME; i++) begin
            step(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
                 ((i % 37) == 0) ? 2'($urandom_range(0, 3)) : pattern_sel);
        end

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
